// File: rtl/avg_stb_gen.sv
// Measures the averaged period of sig_i, then emits a phase-locked strobe of len_i cycles at delay_i.
// Optional edge timeouts are enabled by defining AVG_STB_GEN_TIMEOUT_EN.
module avg_stb_gen #(
  parameter int CNT_WIDTH      = 32,
  parameter int AVG_LOG2       = 2,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sig_i,
  input  logic                 run_i,
  input  logic [CNT_WIDTH-1:0] delay_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 stb_o,
  output logic                 rdy_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] period_o
);

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    ARM  = 6'b000010,
    MEAS = 6'b000100,
    CALC = 6'b001000,
    RUN  = 6'b010000,
    ERR  = 6'b100000
  } state_t;

  localparam logic [8:0] EDGE_LAST = 9'((1 << AVG_LOG2) - 1);

  if (CNT_WIDTH < 8 || CNT_WIDTH > 32 || AVG_LOG2 < 0 || AVG_LOG2 > 8 || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("avg_stb_gen: illegal parameter value");
  end

  state_t               r_state;
  logic                 r_sync1, r_sync2, r_sync3, r_edge;
  logic [1:0]           r_fill;
  logic [CNT_WIDTH-1:0] r_t_cnt, r_t_start, r_t_end, r_ph, r_delay;
  logic [LEN_WIDTH-1:0] r_len, r_lcnt;
  logic [8:0]           r_ecnt;
  logic [CNT_WIDTH-1:0] w_diff, w_period;
  logic                 w_bad, w_ph_wrap, w_hit;

  assign w_diff    = r_t_end - r_t_start;
  assign w_period  = w_diff >> AVG_LOG2;
  assign w_bad     = (w_period < CNT_WIDTH'(2)) || (delay_i >= w_period);
  assign w_ph_wrap = (r_ph == period_o - CNT_WIDTH'(1));
  assign w_hit     = (r_ph == r_delay) && (r_len != LEN_WIDTH'(0));

`ifdef AVG_STB_GEN_TIMEOUT_EN
  logic [33:0] r_to;
  logic        w_to_fire;

  assign w_to_fire = !r_edge &&
                     ((((r_state == ARM) || (r_state == MEAS)) && (r_to == 34'(TIMEOUT_CYCLES - 1))) ||
                      ((r_state == RUN) && (r_to == 34'({period_o, 1'b0}) - 34'd1)));

  // Consecutive cycles without an edge while waiting on or tracking sig_i
  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i || r_edge) begin
      r_to <= 34'd0;
    end else if ((r_state == ARM) || (r_state == MEAS) || (r_state == RUN)) begin
      r_to <= r_to + 34'd1;
    end else begin
      r_to <= 34'd0;
    end
  end
`endif

  // Synchroniser and rising-edge detector; edges are masked until the chain holds real samples
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
      r_fill  <= 2'd0;
    end else begin
      r_sync1 <= sig_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= (r_fill == 2'd3) && r_sync2 && !r_sync3;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end else begin
        r_fill <= r_fill;
      end
    end
  end

  // Free-running time base
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_t_cnt <= CNT_WIDTH'(0);
    end else begin
      r_t_cnt <= r_t_cnt + CNT_WIDTH'(1);
    end
  end

  // Measurement / strobe state machine with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      stb_o     <= 1'b0;
      rdy_o     <= 1'b0;
      err_o     <= 1'b0;
      period_o  <= CNT_WIDTH'(0);
      r_ph      <= CNT_WIDTH'(0);
      r_t_start <= CNT_WIDTH'(0);
      r_t_end   <= CNT_WIDTH'(0);
      r_delay   <= CNT_WIDTH'(0);
      r_len     <= LEN_WIDTH'(0);
      r_lcnt    <= LEN_WIDTH'(0);
      r_ecnt    <= 9'd0;
    end else if (!run_i) begin
      r_state <= IDLE;
      stb_o   <= 1'b0;
      rdy_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= ARM;
        ARM: begin
          if (r_edge) begin
            r_t_start <= r_t_cnt;
            r_ecnt    <= 9'd0;
            r_state   <= MEAS;
          end
        end
        MEAS: begin
          if (r_edge) begin
            if (r_ecnt == EDGE_LAST) begin
              r_t_end <= r_t_cnt;
              r_ph    <= CNT_WIDTH'(0);
              r_state <= CALC;
            end else begin
              r_ecnt <= r_ecnt + 9'd1;
            end
          end
        end
        CALC: begin
          period_o <= w_period;
          r_delay  <= delay_i;
          r_len    <= len_i;
          if (w_bad) begin
            r_state <= ERR;
            err_o   <= 1'b1;
          end else begin
            r_state <= RUN;
            rdy_o   <= 1'b1;
            r_ph    <= CNT_WIDTH'(1);
            // ph is 0 in this cycle, so a zero delay fires immediately
            if ((delay_i == CNT_WIDTH'(0)) && (len_i != LEN_WIDTH'(0))) begin
              stb_o  <= 1'b1;
              r_lcnt <= len_i;
            end
          end
        end
        RUN: begin
          r_ph <= w_ph_wrap ? CNT_WIDTH'(0) : r_ph + CNT_WIDTH'(1);
          if (w_hit) begin
            stb_o  <= 1'b1;
            r_lcnt <= r_len;
          end else if (stb_o) begin
            if (r_lcnt == LEN_WIDTH'(1)) begin
              stb_o <= 1'b0;
            end else begin
              r_lcnt <= r_lcnt - LEN_WIDTH'(1);
            end
          end
        end
        ERR: begin
          stb_o <= 1'b0;
          rdy_o <= 1'b0;
          err_o <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          stb_o   <= 1'b0;
          rdy_o   <= 1'b0;
          err_o   <= 1'b0;
        end
      endcase
`ifdef AVG_STB_GEN_TIMEOUT_EN
      if (w_to_fire) begin
        r_state <= ERR;
        stb_o   <= 1'b0;
        rdy_o   <= 1'b0;
        err_o   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/avg_stb_gen.md
AVG_STB_GEN -- requirements
Module: avg_stb_gen

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32: width of the free-running time counter and period result (legal 8..32).
REQ-002 The block SHALL have parameter AVG_LOG2, default 2: period averaged over 2^AVG_LOG2 intervals (legal 0..8).
REQ-003 The block SHALL have parameter LEN_WIDTH, default 16: width of the strobe length input.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 2^20: edge timeout, used only with the macro in REQ-023.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- sig_i  in  1  asynchronous periodic input.
- run_i  in  1  level; high = measure then strobe, low = idle.
- delay_i  in  CNT_WIDTH  strobe offset from reference edge, in cycles.
- len_i  in  LEN_WIDTH  strobe high time, in cycles.
- stb_o  out  1  registered strobe.
- rdy_o  out  1  period valid and strobing.
- err_o  out  1  sticky error.
- period_o  out  CNT_WIDTH  averaged period, in cycles.

Function
REQ-006 sig_i SHALL pass a 2-FF synchroniser and a registered rising-edge detector; edge pulse e SHALL assert for exactly one cycle, 3 cycles after a sig_i rise that meets setup.
REQ-007 A CNT_WIDTH free-running counter t_cnt SHALL increment every cycle and wrap modulo 2^CNT_WIDTH.
REQ-008 The FSM SHALL be one-hot with states IDLE, ARM, MEAS, CALC, RUN and ERR.
REQ-009 FSM transitions SHALL be:
- IDLE->ARM when run_i=1.
- ARM->MEAS on e, latching t_start=t_cnt.
- MEAS counts e; on the 2^AVG_LOG2-th e it SHALL latch t_end=t_cnt and go to CALC.
- CALC->RUN, or CALC->ERR per REQ-012.
REQ-010 run_i=0 in any state SHALL force IDLE next cycle, with stb_o=0, rdy_o=0 and err_o=0 on that edge; period_o SHALL hold.
REQ-011 CALC SHALL compute period_o=((t_end-t_start) mod 2^CNT_WIDTH)>>AVG_LOG2 (truncating); this is valid across t_cnt wrap provided the total interval is below 2^CNT_WIDTH.
REQ-012 CALC SHALL latch delay_i and len_i; if period<2 or delay_i>=period, it SHALL go to ERR with err_o=1 from the next cycle.
REQ-013 On CALC->RUN, rdy_o SHALL rise on the same edge and stay high until IDLE or ERR.
REQ-014 Phase counter ph SHALL be 0 in the cycle after the measuring e that latched t_end, increment each cycle, and wrap from period-1 to 0; ph SHALL free-run and SHALL NOT resync to later edges.
REQ-015 Strobe timing SHALL be:
- stb_o rises on the cycle after ph==delay.
- stb_o stays high exactly len cycles, then falls.
- len=0 SHALL give no strobe.
- ph==delay while stb_o is already high SHALL restart the len count, so len>=period holds stb_o continuously high.
REQ-016 An e coinciding with the IDLE->ARM transition SHALL NOT be counted.
REQ-017 ERR SHALL hold stb_o=0 and rdy_o=0, keep err_o=1, and exit only via run_i=0 or rst_i.
REQ-018 delay_i and len_i changes during RUN SHALL be ignored until a new run.

Reset
REQ-019 rst_i=1 at a clock edge SHALL set state=IDLE, stb_o=0, rdy_o=0, err_o=0, period_o=0, t_cnt=0, ph=0 and the sync/edge registers to 0.
REQ-020 rst_i SHALL take priority over run_i and all FSM events, including mid-RUN and mid-strobe.
REQ-021 After rst_i deasserts, the first e SHALL NOT be generated from synchroniser reset values alone.
REQ-022 No output SHALL change asynchronously.

Configuration
REQ-023 With AVG_STB_GEN_TIMEOUT_EN defined, edge timeouts SHALL force ERR:
- ARM or MEAS with no e for TIMEOUT_CYCLES consecutive cycles.
- RUN with no e for 2*period consecutive cycles.
REQ-024 Without AVG_STB_GEN_TIMEOUT_EN, no timeout logic SHALL exist; ARM/MEAS wait indefinitely, and RUN ignores missing edges.

Verification
REQ-025 The bench SHALL cover these scenarios:
- AVG_LOG2=2, sig_i period 100, delay_i=10, len_i=5 -> rdy_o rises after 5th edge, period_o=100, stb_o high 5 cycles every 100 cycles, rising 11 cycles after the CALC-triggering e.
- sig_i period alternating 99/101, AVG_LOG2=2 -> period_o=100; AVG_LOG2=0 with period 150 -> period_o=150 after 2 edges.
- CNT_WIDTH=12, measurement straddling t_cnt 4095->0, period 300 -> period_o=300.
- period 100, delay_i=120 -> err_o=1, rdy_o=0, stb_o never high; then run_i=0 -> err_o=0 next cycle.
- RUN with stb_o high, then run_i=0 (and separately rst_i=1) -> stb_o=0, rdy_o=0 next cycle; re-run remeasures.
- Macro defined, TIMEOUT_CYCLES=1000, sig_i held low after run_i=1 -> err_o=1 at cycle 1001; macro undefined -> stays in ARM, err_o=0.
